// File: rtl/fpa_dot_seq.sv
// ---------------------------------------------------------------------------
// fpa_dot_seq.sv
//
// Purpose
//   Single-precision dot-product sequencer, sum(A[i]*B[i]), built around one
//   combinational floating-point stage (fpa, defined in this file). Each
//   streamed element takes three cycles: LOAD (accept), MUL (product
//   capture), ADD (accumulate). The final sum is offered on a valid/ready
//   output.
//
// Optional feature macro
//   FPA_DOT_NAN_FLAG_EN : adds the sticky nan_seen output.
//
// fpa ports
//   number_a, number_b  [31:0] in   IEEE-754 single operands
//   operator            1      in   1 = multiply, 0 = add
//   number_out          [31:0] out  result, round to nearest even
//
// fpa_dot_seq ports
//   clk, rst            in   clock, synchronous active-high reset
//   start, len          in   begin a dot product of len elements (IDLE only)
//   in_valid, in_ready       element handshake; in_a/in_b are the operands
//   out_valid, out_ready     result handshake; out_result is the sum
//   busy                out  high whenever the FSM is not in IDLE
//   remaining           out  elements not yet accepted
//   nan_seen            out  (FPA_DOT_NAN_FLAG_EN only) NaN was captured
//
// fpa arithmetic notes
//   Subnormal inputs are treated as zero and underflowing results flush to
//   signed zero. Any NaN result is the canonical quiet NaN 0x7FC00000.
// ---------------------------------------------------------------------------

module fpa (
  input  logic [31:0] number_a,
  input  logic [31:0] number_b,
  input  logic        operator,
  output logic [31:0] number_out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa     = number_a[31];
  assign ea     = number_a[30:23];
  assign fa     = number_a[22:0];
  assign sb     = number_b[31];
  assign eb     = number_b[30:23];
  assign fb     = number_b[22:0];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);

  // Round to nearest even, then pack; overflow -> inf, underflow -> zero.
  function automatic logic [31:0] round_pack(input logic s,
                                             input logic signed [10:0] e,
                                             input logic [22:0] m,
                                             input logic g,
                                             input logic st);
    logic [23:0]        mr;
    logic signed [10:0] er;
    logic [31:0]        res;
    mr = {1'b0, m} + {23'd0, g & (st | m[0])};
    er = e + $signed({10'd0, mr[23]});
    if (er >= 11'sd255)
      res = {s, 8'hFF, 23'd0};
    else if (er <= 11'sd0)
      res = {s, 31'd0};
    else
      res = {s, er[7:0], mr[22:0]};
    return res;
  endfunction

  // ---------------- multiply ----------------
  logic [47:0]        prod;
  logic signed [10:0] e_mul;
  logic [31:0]        mul_out;

  always_comb begin
    prod    = 48'({1'b1, fa}) * 48'({1'b1, fb});
    e_mul   = 11'sd0;
    mul_out = 32'd0;
    if (prod[47]) begin
      e_mul   = 11'(ea) + 11'(eb) - 11'd126;
      mul_out = round_pack(sa ^ sb, e_mul, prod[46:24], prod[23], |prod[22:0]);
    end else begin
      e_mul   = 11'(ea) + 11'(eb) - 11'd127;
      mul_out = round_pack(sa ^ sb, e_mul, prod[45:23], prod[22], |prod[21:0]);
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      mul_out = QNAN;
    else if (a_inf || b_inf)
      mul_out = {sa ^ sb, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      mul_out = {sa ^ sb, 31'd0};
  end

  // ---------------- add ----------------
  // Operands are ordered by magnitude so the difference is never negative.
  // Mantissas sit at [47:24] of a 49-bit field: bit 48 catches the carry and
  // the low 24 bits keep guard/sticky; bits shifted out during alignment are
  // folded into bit 0.
  logic               swap, s_big;
  logic [7:0]         e_big, e_small, diff;
  logic [5:0]         shamt, lzc;
  logic [48:0]        big_e, small_e, shifted, aligned, sum;
  logic [47:0]        norm;
  logic signed [10:0] e_add;
  logic [31:0]        add_out;

  always_comb begin
    swap    = {eb, fb} > {ea, fa};
    s_big   = swap ? sb : sa;
    e_big   = swap ? eb : ea;
    e_small = swap ? ea : eb;
    big_e   = {1'b0, 1'b1, (swap ? fb : fa), 24'd0};
    small_e = {1'b0, 1'b1, (swap ? fa : fb), 24'd0};
    diff    = e_big - e_small;
    shamt   = (diff > 8'd49) ? 6'd49 : diff[5:0];
    shifted = small_e >> shamt;
    aligned = {shifted[48:1], shifted[0] | ((shifted << shamt) != small_e)};
    sum     = (sa ^ sb) ? (big_e - aligned) : (big_e + aligned);
    lzc     = 6'd49;
    for (int i = 0; i < 49; i++)
      if (sum[i]) lzc = 6'(48 - i);
    norm    = 48'(sum << lzc);
    e_add   = 11'(e_big) + 11'd1 - 11'(lzc);
    add_out = round_pack(s_big, e_add, norm[47:25], norm[24], |norm[23:0]);
    if (sum == 49'd0)
      add_out = 32'd0;
    if (a_nan || b_nan)
      add_out = QNAN;
    else if (a_inf && b_inf)
      add_out = (sa != sb) ? QNAN : {sa, 8'hFF, 23'd0};
    else if (a_inf)
      add_out = {sa, 8'hFF, 23'd0};
    else if (b_inf)
      add_out = {sb, 8'hFF, 23'd0};
    else if (a_zero && b_zero)
      add_out = {sa & sb, 31'd0};
    else if (a_zero)
      add_out = number_b;
    else if (b_zero)
      add_out = number_a;
  end

  assign number_out = operator ? mul_out : add_out;

endmodule

// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start
// LOAD  | in_ready high, waiting for the next element
// MUL   | fpa multiplies op_a*op_b, product captured
// ADD   | fpa adds acc+product, acc updated (first element copied)
// DONE  | out_valid high until out_ready
// ---------------------------------------------------------------------------
module fpa_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             busy,
  output logic [LEN_W-1:0] remaining
`ifdef FPA_DOT_NAN_FLAG_EN
  ,
  output logic             nan_seen
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [31:0] op_a, op_b, product, acc, acc_next;
  logic        first;
  logic [31:0] fpa_a, fpa_b, fpa_out;
  logic        fpa_op;

  fpa u_fpa (
    .number_a   (fpa_a),
    .number_b   (fpa_b),
    .operator   (fpa_op),
    .number_out (fpa_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    fpa_a      = op_a;
    fpa_b      = op_b;
    fpa_op     = 1'b1;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != S_IDLE);
    // The first element is copied rather than added to zero so -0 survives.
    acc_next   = first ? product : fpa_out;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = (len != '0) ? S_LOAD : S_DONE;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_MUL;
      end
      S_MUL: begin
        state_next = S_ADD;
      end
      S_ADD: begin
        fpa_a      = acc;
        fpa_b      = product;
        fpa_op     = 1'b0;
        state_next = (remaining != '0) ? S_LOAD : S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      product    <= 32'd0;
      acc        <= 32'd0;
      first      <= 1'b0;
      remaining  <= '0;
      out_result <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining <= len;
              acc       <= 32'd0;
              first     <= 1'b1;
            end else begin
              out_result <= 32'd0;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            op_a      <= in_a;
            op_b      <= in_b;
            remaining <= remaining - {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        S_MUL: product <= fpa_out;
        S_ADD: begin
          acc   <= acc_next;
          first <= 1'b0;
          if (remaining == '0) out_result <= acc_next;
        end
        default: ;
      endcase
    end
  end

`ifdef FPA_DOT_NAN_FLAG_EN
  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      nan_seen <= 1'b0;
    else if (state == S_IDLE && start)
      nan_seen <= 1'b0;
    else if (state == S_MUL && is_nan(fpa_out))
      nan_seen <= 1'b1;
    else if (state == S_ADD && is_nan(acc_next))
      nan_seen <= 1'b1;
  end
`else
  // No NaN tracking in this build.
`endif

endmodule

// File: tb/tb_fpa_dot_seq.sv
module tb_fpa_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;
  logic [7:0]  remaining;
`ifdef FPA_DOT_NAN_FLAG_EN
  logic        nan_seen;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpa_dot_seq #(.LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .remaining  (remaining)
`ifdef FPA_DOT_NAN_FLAG_EN
    ,
    .nan_seen   (nan_seen)
`endif
  );

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [7:0]       gap;
    logic [31:0]      res;
    logic [7:0]       lat;
    logic             nan;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] l,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                              input logic [7:0] g, input logic [31:0] r, input logic [7:0] lt,
                              input logic nn);
    vec_t v;
    v.len = l;
    v.a   = {32'd0, a2, a1, a0};
    v.b   = {32'd0, b2, b1, b0};
    v.gap = g;
    v.res = r;
    v.lat = lt;
    v.nan = nn;
    return v;
  endfunction

  // Drive one dot product with out_ready held high and check result,
  // latency, remaining and the return to IDLE.
  task automatic run_vec(input vec_t v, input int id);
    int   lat, idx, gap_cnt;
    bit   done, hs, saw_ready;
    string tag;
    tag = $sformatf("vec%0d", id);
    lat = 0; idx = 0; gap_cnt = 0; done = 0; saw_ready = 0;
    out_ready = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    len      = v.len;
    in_valid = (v.len != 0);
    in_a     = v.a[0];
    in_b     = v.b[0];
    while (!done && lat < 200) begin
      hs = in_valid && in_ready;
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (hs) begin
        idx++;
        gap_cnt = 0;
        check({tag, "_remaining"}, 32'(remaining), 32'(v.len) - 32'(idx));
      end
      if (lat == 1 && v.len != 0)
        check({tag, "_remaining_init"}, 32'(remaining), 32'(v.len));
      if (in_ready) saw_ready = 1;
      if (out_valid) begin
        done = 1;
        in_valid = 1'b0;
      end else if (idx >= int'(v.len)) begin
        in_valid = 1'b0;
      end else if (idx > 0 && gap_cnt < int'(v.gap)) begin
        in_valid = 1'b0;
        if (in_ready) gap_cnt++;
      end else begin
        in_valid = 1'b1;
        in_a     = v.a[idx];
        in_b     = v.b[idx];
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check({tag, "_result"}, out_result, v.res);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (v.len == 0) check({tag, "_in_ready_seen"}, 32'(saw_ready), 32'd0);
`ifdef FPA_DOT_NAN_FLAG_EN
    check({tag, "_nan_seen"}, 32'(nan_seen), 32'(v.nan));
`endif
    @(negedge clk);
    check({tag, "_out_valid_fall"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_result"}, out_result, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_remaining"}, 32'(remaining), 32'd0);
`ifdef FPA_DOT_NAN_FLAG_EN
    check({tag, "_nan_seen"}, 32'(nan_seen), 32'd0);
`endif
  endtask

  initial begin
    int  w;
    bit  seen;
    // len, A0..A2, B0..B2, gap, result, latency, nan
    vecs[0] = mk(8'd2, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 32'h40800000, 32'h0, 8'd0, 32'h41300000, 8'd7, 1'b0);
    vecs[1] = mk(8'd1, 32'h40000000, 32'h0, 32'h0, 32'h3F000000, 32'h0, 32'h0, 8'd0, 32'h3F800000, 8'd4, 1'b0);
    vecs[2] = mk(8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 32'h00000000, 8'd1, 1'b0);
    vecs[3] = mk(8'd2, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 32'h40800000, 32'h0, 8'd3, 32'h41300000, 8'd10, 1'b0);
    vecs[4] = mk(8'd3, 32'h3FC00000, 32'hC0000000, 32'h3E800000, 32'h40000000, 32'h40400000, 32'h40800000, 8'd0, 32'hC0000000, 8'd10, 1'b0);
    vecs[5] = mk(8'd1, 32'h80000000, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 8'd0, 32'h80000000, 8'd4, 1'b0);
    vecs[6] = mk(8'd2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h3F800000, 32'h3F800000, 32'h0, 8'd0, 32'h00000000, 8'd7, 1'b0);
    vecs[7] = mk(8'd2, 32'h7F800000, 32'h3F800000, 32'h0, 32'h3F800000, 32'h3F800000, 32'h0, 8'd0, 32'h7F800000, 8'd7, 1'b0);
    vecs[8] = mk(8'd3, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 8'd0, 32'h3F400000, 8'd10, 1'b0);
    vecs[9] = mk(8'd2, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000, 32'h3F800000, 32'h0, 8'd0, 32'h3F800000, 8'd7, 1'b0);

    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // NaN operand: canonical quiet NaN result, flag set when enabled.
    run_vec(mk(8'd1, 32'h7FC00000, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 8'd0, 32'h7FC00000, 8'd4, 1'b1), 10);

    // Result held under backpressure; start in DONE and at handshake ignored.
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1; len = 8'd1; in_valid = 1'b1;
    in_a = 32'h40000000; in_b = 32'h3F000000;
    seen = 0;
    for (w = 0; w < 50 && !seen; w++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) seen = 1;
    end
    in_valid = 1'b0;
    check("hold_reached_done", 32'(seen), 32'd1);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", out_result, 32'h3F800000);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check("handshake_out_valid", 32'(out_valid), 32'd0);
    check("handshake_start_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    check("handshake_still_idle", 32'(busy), 32'd0);

    // Reset during ADD of the first of two elements aborts the run.
    start = 1'b1; len = 8'd2; in_valid = 1'b1;
    in_a = 32'h3F800000; in_b = 32'h40400000;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    check("abort_in_add_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    run_vec(mk(8'd1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 8'd0, 32'h3F800000, 8'd4, 1'b0), 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
